// File: rtl/fifo_w2n_pkg.sv
// Shared definitions for the byte-in / word-out FIFO family.
//   BYTES_PER_WORD : bytes assembled into one read word
//   parity8        : even parity of a (zero-extended) data byte
//   slot_mask      : BYTES_PER_WORD-long run of ones starting at ptr, wrapping at depth
package fifo_w2n_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned MAX_DATA_WIDTH = 32;
   localparam int unsigned MAX_DEPTH      = 1024;
   localparam int unsigned MAX_DEPTH_AW   = 10;

   // Zero-extension of narrower data leaves the parity unchanged.
   function automatic logic parity8(input logic [MAX_DATA_WIDTH-1:0] d);
      return ^d;
   endfunction

   // Caller truncates the result to its own DEPTH.
   function automatic logic [MAX_DEPTH-1:0] slot_mask(input int unsigned ptr,
                                                      input int unsigned depth);
      logic [MAX_DEPTH-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
         m[MAX_DEPTH_AW'((ptr + k) % depth)] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/fifo_parity_mem.sv
// Byte storage with a stored parity bit per slot.
//   clk             : write clock
//   i_we            : write enable
//   i_waddr         : write slot
//   i_wentry        : {parity, byte} to store
//   i_raddr         : first slot of the four-slot read window
//   o_rd_entries_c  : combinational {parity, byte} for slots raddr..raddr+3 (wrapping)
module fifo_parity_mem
   import fifo_w2n_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 2**ADDR_WIDTH
)(
   input  logic                                       clk,
   input  logic                                       i_we,
   input  logic [ADDR_WIDTH-1:0]                      i_waddr,
   input  logic [DATA_WIDTH:0]                        i_wentry,
   input  logic [ADDR_WIDTH-1:0]                      i_raddr,
   output logic [BYTES_PER_WORD-1:0][DATA_WIDTH:0]    o_rd_entries_c
);

   logic [DATA_WIDTH:0] r_mem [DEPTH];

   // Storage is intentionally not reset; occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wentry;
      end
   end

   // Read window wraps naturally through the address width.
   always_comb begin
      o_rd_entries_c = '0;
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
         o_rd_entries_c[k] = r_mem[i_raddr + ADDR_WIDTH'(k)];
      end
   end

endmodule

// File: rtl/fifo_8to32_v2.sv
// Byte-in, word-out width-converting FIFO with per-slot occupancy and read parity check.
//   clk, rst      : clock, asynchronous active-high reset
//   w_data, wr_en : write byte and request (ignored when full)
//   rd_en         : word read request (ignored when fewer than four bytes held)
//   r_data        : last read word, oldest byte in the low bits
//   empty, full   : fewer than four bytes / all slots occupied
//   status_reg    : bit i set while slot i holds valid data
//   parity_error  : parity mismatch seen on the last read
module fifo_8to32_v2
   import fifo_w2n_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 2**ADDR_WIDTH,
   parameter int unsigned READ_WIDTH = 4*DATA_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic [READ_WIDTH-1:0] r_data,
   input  logic                  rd_en,
   output logic                  empty,
   output logic [DEPTH-1:0]      status_reg,
   output logic                  parity_error
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned ENT_W = DATA_WIDTH + 1;

   logic [ADDR_WIDTH-1:0]                  r_wr_ptr;
   logic [ADDR_WIDTH-1:0]                  r_rd_ptr;
   logic [CNT_W-1:0]                       r_count;
   logic                                   r_empty;
   logic                                   r_full;

   logic                                   w_wr_fire;
   logic                                   w_rd_fire;
   logic [ENT_W-1:0]                       w_wr_entry;
   logic [BYTES_PER_WORD-1:0][ENT_W-1:0]   w_rd_entries;
   logic [CNT_W-1:0]                       w_count_nxt;
   logic [DEPTH-1:0]                       w_status_nxt;
   logic [READ_WIDTH-1:0]                  w_rd_word;
   logic                                   w_par_err;

   assign w_wr_fire  = wr_en & ~r_full;
   assign w_rd_fire  = rd_en & ~r_empty;
   assign w_wr_entry = {parity8(MAX_DATA_WIDTH'(w_data)), w_data};
   assign full       = r_full;
   assign empty      = r_empty;

   fifo_parity_mem #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk            (clk),
      .i_we           (w_wr_fire),
      .i_waddr        (r_wr_ptr),
      .i_wentry       (w_wr_entry),
      .i_raddr        (r_rd_ptr),
      .o_rd_entries_c (w_rd_entries)
   );

   // Occupancy: +1 write, -4 read, -3 both.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_fire, w_rd_fire})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(BYTES_PER_WORD);
         2'b11:   w_count_nxt = r_count - CNT_W'(BYTES_PER_WORD - 1);
         default: w_count_nxt = r_count;
      endcase
   end

   // The written slot never overlaps the read window, so set/clear order is irrelevant.
   always_comb begin
      w_status_nxt = status_reg;
      if (w_wr_fire) begin
         w_status_nxt = w_status_nxt | (DEPTH'(1) << r_wr_ptr);
      end
      if (w_rd_fire) begin
         w_status_nxt = w_status_nxt & ~DEPTH'(slot_mask(32'(r_rd_ptr), DEPTH));
      end
   end

   // Word assembly and per-byte parity recheck.
   always_comb begin
      w_rd_word = '0;
      w_par_err = 1'b0;
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
         w_rd_word[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_entries[k][DATA_WIDTH-1:0];
         w_par_err = w_par_err |
            (parity8(MAX_DATA_WIDTH'(w_rd_entries[k][DATA_WIDTH-1:0])) != w_rd_entries[k][DATA_WIDTH]);
      end
   end

   // Flags are registered from the next count, so they track count with no extra lag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_empty      <= 1'b1;
         r_full       <= 1'b0;
         status_reg   <= '0;
         r_data       <= '0;
         parity_error <= 1'b0;
      end else begin
         if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_rd_fire) begin
            r_rd_ptr     <= r_rd_ptr + ADDR_WIDTH'(BYTES_PER_WORD);
            r_data       <= w_rd_word;
            parity_error <= w_par_err;
         end
         if (w_wr_fire | w_rd_fire) begin
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt < CNT_W'(BYTES_PER_WORD));
            r_full     <= (w_count_nxt == CNT_W'(DEPTH));
            status_reg <= w_status_nxt;
         end
      end
   end

endmodule

// File: tb/tb_fifo_8to32_v2.sv
// Directed bench for fifo_8to32_v2 with a byte-queue reference model.
module tb_fifo_8to32_v2;

   logic        clk;
   logic        rst;
   logic [7:0]  w_data;
   logic        wr_en;
   logic        full;
   logic [31:0] r_data;
   logic        rd_en;
   logic        empty;
   logic [15:0] status_reg;
   logic        parity_error;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mq[$];
   logic [31:0] m_word;
   logic        m_rd_fired;
   logic        m_wr_fired;
   int          m_wp;
   int          m_rp;

   fifo_8to32_v2 dut (
      .clk          (clk),
      .rst          (rst),
      .w_data       (w_data),
      .wr_en        (wr_en),
      .full         (full),
      .r_data       (r_data),
      .rd_en        (rd_en),
      .empty        (empty),
      .status_reg   (status_reg),
      .parity_error (parity_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of requests and advance the reference model past the edge.
   task automatic step(input logic we, input logic re, input logic [7:0] d);
      logic wf, rf;
      wf = we && (mq.size() < 16);
      rf = re && (mq.size() >= 4);
      wr_en  = we;
      rd_en  = re;
      w_data = d;
      @(posedge clk);
      #1;
      if (rf) begin
         m_word = {mq[3], mq[2], mq[1], mq[0]};
         repeat (4) void'(mq.pop_front());
         m_rp = (m_rp + 4) % 16;
      end
      if (wf) begin
         mq.push_back(d);
         m_wp = (m_wp + 1) % 16;
      end
      m_rd_fired = rf;
      m_wr_fired = wf;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; w_data = 8'h00;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete(); m_wp = 0; m_rp = 0; m_word = '0;
      @(posedge clk); #1;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
      checks++; if (status_reg !== 16'h0000) begin errors++; $display("FAIL reset_status got %h exp 0000", status_reg); end
      checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity got %b exp 0", parity_error); end
      checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", r_data); end
   endtask

   logic [7:0] fill_b [16];

   task automatic test_fill();
      fill_b = '{8'h3C, 8'hA5, 8'h01, 8'hFF, 8'h7E, 8'h80, 8'h55, 8'hC3,
                 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, fill_b[i]);
         if (i == 3) begin
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty4 got %b exp 0", empty); end
         end
         if (i == 7) begin
            checks++; if (status_reg !== 16'h00FF) begin errors++; $display("FAIL fill_status8 got %h exp 00FF", status_reg); end
         end
      end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
      checks++; if (status_reg !== 16'hFFFF) begin errors++; $display("FAIL fill_status got %h exp FFFF", status_reg); end
      step(1'b1, 1'b0, 8'hEE);
      checks++; if (dut.r_count !== 5'd16) begin errors++; $display("FAIL overflow_count got %0d exp 16", dut.r_count); end
      checks++; if (dut.r_wr_ptr !== 4'd0) begin errors++; $display("FAIL overflow_wrptr got %0d exp 0", dut.r_wr_ptr); end
      checks++; if (status_reg !== 16'hFFFF) begin errors++; $display("FAIL overflow_status got %h exp FFFF", status_reg); end
   endtask

   task automatic test_drain();
      logic [31:0] exp_w;
      for (int i = 0; i < 4; i++) begin
         exp_w = {fill_b[4*i+3], fill_b[4*i+2], fill_b[4*i+1], fill_b[4*i]};
         step(1'b0, 1'b1, 8'h00);
         checks++; if (r_data !== exp_w) begin errors++; $display("FAIL drain_word%0d got %h exp %h", i, r_data, exp_w); end
         checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL drain_parity%0d got %b exp 0", i, parity_error); end
         if (i == 0) begin
            checks++; if (status_reg !== 16'hFFF0) begin errors++; $display("FAIL drain_status1 got %h exp FFF0", status_reg); end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full1 got %b exp 0", full); end
         end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
      checks++; if (status_reg !== 16'h0000) begin errors++; $display("FAIL drain_status got %h exp 0000", status_reg); end
      step(1'b0, 1'b1, 8'h00);
      checks++; if (r_data !== 32'hF0DEBC9A) begin errors++; $display("FAIL underflow_hold got %h exp F0DEBC9A", r_data); end
   endtask

   task automatic test_concurrent();
      int wr_left, rd_left, wg, rg, cyc;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
      // Same-cycle write and read: read returns 43424140, count 4 -> 1.
      step(1'b1, 1'b1, 8'h44);
      checks++; if (r_data !== 32'h43424140) begin errors++; $display("FAIL both_word got %h exp 43424140", r_data); end
      checks++; if (status_reg !== 16'h0010) begin errors++; $display("FAIL both_status got %h exp 0010", status_reg); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL both_empty got %b exp 1", empty); end
      wr_left = 15; rd_left = 4;
      wg = $urandom_range(0, 2); rg = $urandom_range(0, 2); cyc = 0;
      while ((wr_left > 0 || rd_left > 0) && cyc < 300) begin
         step(wr_left > 0 && wg == 0, rd_left > 0 && rg == 0, 8'($urandom));
         cyc++;
         if (m_wr_fired) begin wr_left--; wg = $urandom_range(0, 2); end
         else if (wg > 0) wg--;
         if (m_rd_fired) begin
            rd_left--; rg = $urandom_range(0, 2);
            checks++; if (r_data !== m_word) begin errors++; $display("FAIL conc_word got %h exp %h", r_data, m_word); end
         end else if (rg > 0) rg--;
         checks++; if ($countones(status_reg) != mq.size()) begin errors++; $display("FAIL conc_popcount got %0d exp %0d", $countones(status_reg), mq.size()); end
         checks++; if (empty !== (mq.size() < 4)) begin errors++; $display("FAIL conc_empty got %b exp %b", empty, mq.size() < 4); end
         checks++; if (full !== (mq.size() == 16)) begin errors++; $display("FAIL conc_full got %b exp %b", full, mq.size() == 16); end
      end
      checks++; if (wr_left != 0 || rd_left != 0) begin errors++; $display("FAIL conc_timeout got wr_left %0d rd_left %0d exp 0 0", wr_left, rd_left); end
   endtask

   task automatic test_idle();
      logic [31:0] last;
      last = m_word;
      repeat (20) step(1'b0, 1'b0, 8'h5A);
      checks++; if (dut.r_wr_ptr !== 4'(m_wp)) begin errors++; $display("FAIL idle_wrptr got %0d exp %0d", dut.r_wr_ptr, m_wp); end
      checks++; if (dut.r_rd_ptr !== 4'(m_rp)) begin errors++; $display("FAIL idle_rdptr got %0d exp %0d", dut.r_rd_ptr, m_rp); end
      checks++; if (r_data !== last) begin errors++; $display("FAIL idle_rdata got %h exp %h", r_data, last); end
   endtask

   task automatic test_parity();
      // Second byte 0x6B is stored as 0x6A with the parity of 0x6B.
      step(1'b1, 1'b0, 8'h11);
      force dut.w_wr_entry = {1'b1, 8'h6A};
      step(1'b1, 1'b0, 8'h6A);
      release dut.w_wr_entry;
      step(1'b1, 1'b0, 8'h22);
      step(1'b1, 1'b0, 8'h33);
      step(1'b0, 1'b1, 8'h00);
      checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL parity_bad got %b exp 1", parity_error); end
      checks++; if (r_data !== 32'h33226A11) begin errors++; $display("FAIL parity_bad_word got %h exp 33226A11", r_data); end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
      step(1'b0, 1'b1, 8'h00);
      checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL parity_clean got %b exp 0", parity_error); end
      checks++; if (r_data !== 32'hA3A2A1A0) begin errors++; $display("FAIL parity_clean_word got %h exp A3A2A1A0", r_data); end
   endtask

   task automatic test_midreset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
      step(1'b0, 1'b1, 8'h00);
      #2 rst = 1'b1;
      #1;
      checks++; if (status_reg !== 16'h0000) begin errors++; $display("FAIL midrst_status got %h exp 0000", status_reg); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b exp 1", empty); end
      checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h exp 0", r_data); end
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete(); m_wp = 0; m_rp = 0;
      step(1'b1, 1'b0, 8'h99);
      checks++; if (status_reg !== 16'h0001) begin errors++; $display("FAIL postrst_status got %h exp 0001", status_reg); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_concurrent();
      test_idle();
      test_parity();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
